game_digit_timer: RTL and testbench

Two-digit BCD countdown timer that serves as the responder for the game controller's timer interface. It loads a start value on `Reconfig`, counts down one step per second while `Enable_Timer1` is high, and returns a single-cycle `Time_Out_Pulse` when it reaches 00. It holds its count while paused and clears on `Reset_The_Game`. Its digit outputs drive the seven-segment display decoders.

---
 rtl/game_digit_timer.sv | 118 +++++++++++
 tb/tb_game_digit_timer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/game_digit_timer.sv
// Two-digit BCD countdown timer with a prescaler, a pause that keeps the partial second,
// and a one-cycle registered timeout pulse.
module game_digit_timer #(
   parameter int TICKS_PER_SEC = 50_000_000,
   parameter int PRESCALE_W    = 26
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       Reconfig,
   input  logic [3:0] Config_Tens,
   input  logic [3:0] Config_Ones,
   input  logic       Enable_Timer1,
   input  logic       Reset_The_Game,
   output logic       Time_Out_Pulse,
   output logic [3:0] Tens_Digit,
   output logic [3:0] Ones_Digit,
   output logic       Timer_Active
);

   typedef enum logic [1:0] {IDLE, COUNT, EXPIRED} state_t;

   state_t                state_q, state_d;
   logic [3:0]            tens_q, tens_d, ones_q, ones_d;
   logic [PRESCALE_W-1:0] presc_q, presc_d;
   logic                  pulse_q, pulse_d;
   logic                  active_q, active_d;
   logic                  tick, last, zero;

   function automatic logic [3:0] clamp9(input logic [3:0] d);
      return (d > 4'd9) ? 4'd9 : d;
   endfunction

   assign tick = (presc_q == PRESCALE_W'(TICKS_PER_SEC - 1));
   assign last = (tens_q == 4'd0) && (ones_q == 4'd1);
   assign zero = (tens_q == 4'd0) && (ones_q == 4'd0);

   always_comb begin
      state_d  = state_q;
      tens_d   = tens_q;
      ones_d   = ones_q;
      presc_d  = presc_q;
      pulse_d  = 1'b0;
      active_d = 1'b0;
      if (Reset_The_Game) begin
         state_d = IDLE;
         tens_d  = 4'd0;
         ones_d  = 4'd0;
         presc_d = '0;
      end else if (Reconfig) begin
         state_d = IDLE;
         tens_d  = clamp9(Config_Tens);
         ones_d  = clamp9(Config_Ones);
         presc_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (Enable_Timer1) begin
                  if (zero) begin
                     state_d = EXPIRED;
                     pulse_d = 1'b1;
                  end else begin
                     state_d  = COUNT;
                     presc_d  = presc_q + 1'b1;
                     active_d = 1'b1;
                  end
               end
            end
            COUNT: begin
               if (Enable_Timer1) begin
                  active_d = 1'b1;
                  if (tick) begin
                     presc_d = '0;
                     if (ones_q == 4'd0) begin
                        ones_d = 4'd9;
                        tens_d = tens_q - 4'd1;
                     end else begin
                        ones_d = ones_q - 4'd1;
                     end
                     if (last) begin
                        state_d  = EXPIRED;
                        pulse_d  = 1'b1;
                        active_d = 1'b0;
                     end
                  end else begin
                     presc_d = presc_q + 1'b1;
                  end
               end
            end
            EXPIRED: ;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         tens_q   <= 4'd0;
         ones_q   <= 4'd0;
         presc_q  <= '0;
         pulse_q  <= 1'b0;
         active_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         tens_q   <= tens_d;
         ones_q   <= ones_d;
         presc_q  <= presc_d;
         pulse_q  <= pulse_d;
         active_q <= active_d;
      end
   end

   assign Time_Out_Pulse = pulse_q;
   assign Tens_Digit     = tens_q;
   assign Ones_Digit     = ones_q;
   assign Timer_Active   = active_q;

endmodule

// File: tb/tb_game_digit_timer.sv
// Bench for game_digit_timer: value/elapsed-cycle reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_game_digit_timer;
   localparam int TPS = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       Reconfig = 1'b0;
   logic [3:0] Config_Tens = 4'd0;
   logic [3:0] Config_Ones = 4'd0;
   logic       Enable_Timer1 = 1'b0;
   logic       Reset_The_Game = 1'b0;
   logic       Time_Out_Pulse;
   logic [3:0] Tens_Digit;
   logic [3:0] Ones_Digit;
   logic       Timer_Active;

   int total = 0;
   int bad   = 0;

   game_digit_timer #(.TICKS_PER_SEC(TPS), .PRESCALE_W(3)) dut (
      .clk(clk), .rst(rst), .Reconfig(Reconfig), .Config_Tens(Config_Tens),
      .Config_Ones(Config_Ones), .Enable_Timer1(Enable_Timer1),
      .Reset_The_Game(Reset_The_Game), .Time_Out_Pulse(Time_Out_Pulse),
      .Tens_Digit(Tens_Digit), .Ones_Digit(Ones_Digit), .Timer_Active(Timer_Active)
   );

   always #5 clk = ~clk;

   // Model: loaded value v, enabled cycles n since start; shown value = v - n/TPS.
   int m_v = 0, m_n = 0;
   bit m_started = 0, m_exp = 0, m_pulse = 0, m_active = 0;

   function automatic int clamp9(input int d);
      return (d > 9) ? 9 : d;
   endfunction

   always @(posedge clk or negedge rst) begin : model
      int  v, n;
      bit  st, ex, pu, ac;
      if (!rst) begin
         m_v <= 0; m_n <= 0; m_started <= 0; m_exp <= 0; m_pulse <= 0; m_active <= 0;
      end else begin
         v = m_v; n = m_n; st = m_started; ex = m_exp; pu = 0; ac = 0;
         if (Reset_The_Game) begin
            v = 0; n = 0; st = 0; ex = 0;
         end else if (Reconfig) begin
            v = clamp9(Config_Tens) * 10 + clamp9(Config_Ones); n = 0; st = 0; ex = 0;
         end else if (!ex && Enable_Timer1) begin
            if (!st && v == 0) begin
               ex = 1; pu = 1;
            end else begin
               st = 1; n = n + 1;
               if (n == v * TPS) begin ex = 1; pu = 1; end
               else ac = 1;
            end
         end
         m_v <= v; m_n <= n; m_started <= st; m_exp <= ex; m_pulse <= pu; m_active <= ac;
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s at %0t: got=%0d want=%0d", nm, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin : compare
      int d;
      d = m_v - m_n / TPS;
      chk("tens", int'(Tens_Digit), d / 10);
      chk("ones", int'(Ones_Digit), d % 10);
      chk("pulse", int'(Time_Out_Pulse), int'(m_pulse));
      chk("active", int'(Timer_Active), int'(m_active));
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic load(input int t, input int o);
      Reconfig = 1; Config_Tens = 4'(t); Config_Ones = 4'(o);
      step();
      Reconfig = 0;
   endtask

   task automatic steps(input int k);
      for (int i = 0; i < k; i++) step();
   endtask

   initial begin
      int pulses;
      // reset then idle
      steps(3);
      chk("rst_tens", int'(Tens_Digit), 0);
      chk("rst_pulse", int'(Time_Out_Pulse), 0);
      rst = 1;
      steps(20);
      chk("idle_active", int'(Timer_Active), 0);

      // load 03 and expire
      load(0, 3);
      chk("ld3_ones", int'(Ones_Digit), 3);
      Enable_Timer1 = 1;
      steps(11);
      chk("at11_ones", int'(Ones_Digit), 1);
      chk("at11_pulse", int'(Time_Out_Pulse), 0);
      step();
      chk("at12_ones", int'(Ones_Digit), 0);
      chk("at12_pulse", int'(Time_Out_Pulse), 1);
      pulses = 0;
      for (int i = 0; i < 20; i++) begin step(); pulses += int'(Time_Out_Pulse); end
      chk("post_pulses", pulses, 0);
      Enable_Timer1 = 0;

      // pause/resume with BCD borrow
      load(1, 0);
      Enable_Timer1 = 1;
      steps(5);
      chk("p_tens", int'(Tens_Digit), 0);
      chk("p_ones", int'(Ones_Digit), 9);
      Enable_Timer1 = 0;
      steps(10);
      chk("paused_ones", int'(Ones_Digit), 9);
      chk("paused_active", int'(Timer_Active), 0);
      Enable_Timer1 = 1;
      steps(2);
      chk("res2_ones", int'(Ones_Digit), 9);
      step();
      chk("res3_ones", int'(Ones_Digit), 8);
      steps(31);
      chk("at39_pulse", int'(Time_Out_Pulse), 0);
      step();
      chk("at40_pulse", int'(Time_Out_Pulse), 1);
      Enable_Timer1 = 0;

      // clamp and zero load
      load(12, 11);
      chk("clamp_tens", int'(Tens_Digit), 9);
      chk("clamp_ones", int'(Ones_Digit), 9);
      load(0, 0);
      Enable_Timer1 = 1;
      step();
      chk("zero_pulse", int'(Time_Out_Pulse), 1);
      step();
      chk("zero_pulse_off", int'(Time_Out_Pulse), 0);
      Enable_Timer1 = 0;

      // reconfig on the terminal tick wins
      load(0, 1);
      Enable_Timer1 = 1;
      steps(3);
      Reconfig = 1; Config_Tens = 4'd2; Config_Ones = 4'd5;
      step();
      Reconfig = 0; Enable_Timer1 = 0;
      chk("coll_tens", int'(Tens_Digit), 2);
      chk("coll_ones", int'(Ones_Digit), 5);
      chk("coll_pulse", int'(Time_Out_Pulse), 0);

      // game reset beats reconfig
      Reset_The_Game = 1; Reconfig = 1; Config_Tens = 4'd7; Config_Ones = 4'd7;
      step();
      Reset_The_Game = 0; Reconfig = 0;
      chk("rtg_ones", int'(Ones_Digit), 0);
      chk("rtg_pulse", int'(Time_Out_Pulse), 0);

      // async reset mid-count
      load(0, 5);
      Enable_Timer1 = 1;
      steps(2);
      #1 rst = 0;
      #1;
      chk("arst_ones", int'(Ones_Digit), 0);
      chk("arst_active", int'(Timer_Active), 0);
      step();
      rst = 1;
      step();
      chk("arst_en_pulse", int'(Time_Out_Pulse), 1);
      steps(6);
      chk("arst_hold", int'(Ones_Digit), 0);
      Enable_Timer1 = 0;

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         Reset_The_Game = ($urandom_range(0, 63) == 0);
         Reconfig       = ($urandom_range(0, 19) == 0);
         Config_Tens    = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
         Config_Ones    = 4'($urandom_range(0, 15));
         Enable_Timer1  = ($urandom_range(0, 3) != 0);
         step();
      end
      Reset_The_Game = 0; Reconfig = 0; Enable_Timer1 = 0;
      steps(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
